// File: rtl/datapath_pkg.sv
// Shared widths and ALU opcode encodings for the mini-CPU datapath.
package datapath_pkg;

    localparam int WIDTH = 32;
    localparam int NREGS = 16;

    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_SHR  = 5'b00111;
    localparam logic [4:0] OP_SHRA = 5'b01000;
    localparam logic [4:0] OP_SHL  = 5'b01001;
    localparam logic [4:0] OP_ROR  = 5'b01010;
    localparam logic [4:0] OP_ROL  = 5'b01011;
    localparam logic [4:0] OP_DIV  = 5'b01111;
    localparam logic [4:0] OP_MUL  = 5'b10000;
    localparam logic [4:0] OP_NEG  = 5'b10001;
    localparam logic [4:0] OP_NOT  = 5'b10010;

endpackage

// File: rtl/datapath_alu.sv
// Combinational ALU: combines A (Y register) with B (bus) into a 2*WIDTH result for Z.
module datapath_alu
    import datapath_pkg::*;
(
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic [4:0]         opcode,
    output logic [2*WIDTH-1:0] result
);

    logic [4:0]                w_shamt;
    logic [2*WIDTH-1:0]        w_rot_r;
    logic [2*WIDTH-1:0]        w_rot_l;
    logic signed [2*WIDTH-1:0] w_a_ext;
    logic signed [2*WIDTH-1:0] w_b_ext;
    logic signed [2*WIDTH-1:0] w_prod;
    logic signed [WIDTH-1:0]   w_quot;
    logic signed [WIDTH-1:0]   w_rem;

    assign w_shamt = b[4:0];
    // Rotations are shifts of the operand concatenated with itself.
    assign w_rot_r = {a, a} >> w_shamt;
    assign w_rot_l = {a, a} << w_shamt;
    assign w_a_ext = {{WIDTH{a[WIDTH-1]}}, a};
    assign w_b_ext = {{WIDTH{b[WIDTH-1]}}, b};
    assign w_prod  = w_a_ext * w_b_ext;
    assign w_quot  = $signed(a) / $signed(b);
    assign w_rem   = $signed(a) % $signed(b);

    // NOTE: every path starts from a full default so no latch is inferred for unused opcodes.
    always_comb begin
        result = '0;
        case (opcode)
            OP_ADD:  result[WIDTH-1:0] = a + b;
            OP_SUB:  result[WIDTH-1:0] = a - b;
            OP_AND:  result[WIDTH-1:0] = a & b;
            OP_OR:   result[WIDTH-1:0] = a | b;
            OP_SHR:  result[WIDTH-1:0] = a >> w_shamt;
            OP_SHRA: result[WIDTH-1:0] = $signed(a) >>> w_shamt;
            OP_SHL:  result[WIDTH-1:0] = a << w_shamt;
            OP_ROR:  result[WIDTH-1:0] = w_rot_r[WIDTH-1:0];
            OP_ROL:  result[WIDTH-1:0] = w_rot_l[2*WIDTH-1:WIDTH];
            OP_DIV:  if (b != '0) result = {w_rem, w_quot};
            OP_MUL:  result = w_prod;
            OP_NEG:  result[WIDTH-1:0] = '0 - b;
            OP_NOT:  result[WIDTH-1:0] = ~b;
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/datapath.sv
// Single-bus 32-bit datapath: register file, special registers, OR-bus and ALU.
// Define DATAPATH_DEBUG_EN to expose the bus, MAR, PC, HI, LO and Z as debug outputs.
module datapath
    import datapath_pkg::*;
(
    input  logic             clock,
    input  logic             clear,
    input  logic             R0in, R1in, R2in, R3in, R4in, R5in, R6in, R7in,
    input  logic             R8in, R9in, R10in, R11in, R12in, R13in, R14in, R15in,
    input  logic             PCin, HIin, LOin, Yin, MARin, InPortIn, Zin,
    input  logic             incPC, MDRin, read,
    input  logic [4:0]       opcode,
    input  logic             R0out, R1out, R2out, R3out, R4out, R5out, R6out, R7out,
    input  logic             R8out, R9out, R10out, R11out, R12out, R13out, R14out, R15out,
    input  logic             PCout, HIout, LOout, MDRout, InPortOut, ZLowOut, ZHighOut,
    input  logic [WIDTH-1:0] Mdatain
`ifdef DATAPATH_DEBUG_EN
    ,
    output logic [WIDTH-1:0]   bus_dbg,
    output logic [WIDTH-1:0]   mar_dbg,
    output logic [WIDTH-1:0]   pc_dbg,
    output logic [WIDTH-1:0]   hi_dbg,
    output logic [WIDTH-1:0]   lo_dbg,
    output logic [2*WIDTH-1:0] z_dbg
`endif
);

    logic [WIDTH-1:0]   r_regs [NREGS];
    logic [WIDTH-1:0]   r_pc, r_hi, r_lo, r_y, r_mar, r_mdr, r_inport;
    logic [2*WIDTH-1:0] r_z;

    logic [NREGS-1:0]   w_rin, w_rout;
    logic [WIDTH-1:0]   w_bus;
    logic [2*WIDTH-1:0] w_alu_result;

    assign w_rin  = {R15in, R14in, R13in, R12in, R11in, R10in, R9in, R8in,
                     R7in, R6in, R5in, R4in, R3in, R2in, R1in, R0in};
    assign w_rout = {R15out, R14out, R13out, R12out, R11out, R10out, R9out, R8out,
                     R7out, R6out, R5out, R4out, R3out, R2out, R1out, R0out};

    // Wired-OR bus: overlapping out strobes merge rather than being flagged.
    always_comb begin
        w_bus = '0;
        for (int i = 0; i < NREGS; i++) begin
            if (w_rout[i]) w_bus |= r_regs[i];
        end
        if (PCout)     w_bus |= r_pc;
        if (HIout)     w_bus |= r_hi;
        if (LOout)     w_bus |= r_lo;
        if (MDRout)    w_bus |= r_mdr;
        if (InPortOut) w_bus |= r_inport;
        if (ZLowOut)   w_bus |= r_z[WIDTH-1:0];
        if (ZHighOut)  w_bus |= r_z[2*WIDTH-1:WIDTH];
    end

    datapath_alu u_alu (
        .a      (r_y),
        .b      (w_bus),
        .opcode (opcode),
        .result (w_alu_result)
    );

    // NOTE: sequential state uses non-blocking assignments so Z sees the pre-edge Y when Yin and Zin coincide.
    always_ff @(posedge clock) begin
        if (!clear) begin
            // NOTE: the register file is an array of flops, not a RAM, so it is cleared with everything else.
            for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
            r_pc     <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_y      <= '0;
            r_z      <= '0;
            r_mar    <= '0;
            r_mdr    <= '0;
            r_inport <= '0;
        end else begin
            for (int i = 0; i < NREGS; i++) begin
                if (w_rin[i]) r_regs[i] <= w_bus;
            end
            if (PCin)          r_pc <= w_bus;
            else if (incPC)    r_pc <= r_pc + WIDTH'(1);
            if (HIin)     r_hi     <= w_bus;
            if (LOin)     r_lo     <= w_bus;
            if (Yin)      r_y      <= w_bus;
            if (MARin)    r_mar    <= w_bus;
            if (InPortIn) r_inport <= w_bus;
            if (Zin)      r_z      <= w_alu_result;
            if (MDRin)    r_mdr    <= read ? Mdatain : w_bus;
        end
    end

`ifdef DATAPATH_DEBUG_EN
    assign bus_dbg = w_bus;
    assign mar_dbg = r_mar;
    assign pc_dbg  = r_pc;
    assign hi_dbg  = r_hi;
    assign lo_dbg  = r_lo;
    assign z_dbg   = r_z;
`else
    // MAR feeds the memory address only in a full system; nothing consumes it here.
    logic w_mar_unused;
    assign w_mar_unused = ^r_mar;
`endif

endmodule

// File: tb/tb_datapath.sv
// Self-checking bench for datapath: directed test-plan steps plus randomized control steps
// checked every cycle against a behavioural register/bus/ALU model.
module tb_datapath;
    import datapath_pkg::*;

    // In-mask bits: [15:0] Rn, 16 PC, 17 HI, 18 LO, 19 Y, 20 MAR, 21 InPort, 22 Z, 23 MDR
    // Out-mask bits: [15:0] Rn, 16 PC, 17 HI, 18 LO, 19 MDR, 20 InPort, 21 ZLow, 22 ZHigh
    localparam int I_PC = 16, I_HI = 17, I_LO = 18, I_Y = 19, I_MAR = 20, I_INP = 21, I_Z = 22, I_MDR = 23;
    localparam int O_PC = 16, O_HI = 17, O_LO = 18, O_MDR = 19, O_INP = 20, O_ZL = 21, O_ZH = 22;

    logic        clock = 1'b0;
    logic        clear = 1'b1;
    logic [23:0] s_in  = '0;
    logic [22:0] s_out = '0;
    logic        s_inc = 1'b0;
    logic        s_read = 1'b0;
    logic [4:0]  s_op  = '0;
    logic [31:0] s_mdata = '0;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] m_r [16];
    logic [31:0] m_pc, m_hi, m_lo, m_y, m_mar, m_mdr, m_inp;
    logic [63:0] m_z;

`ifdef DATAPATH_DEBUG_EN
    logic [31:0] bus_dbg, mar_dbg, pc_dbg, hi_dbg, lo_dbg;
    logic [63:0] z_dbg;
`endif

    always #5 clock = ~clock;

    datapath dut (
        .clock(clock), .clear(clear),
        .R0in(s_in[0]), .R1in(s_in[1]), .R2in(s_in[2]), .R3in(s_in[3]),
        .R4in(s_in[4]), .R5in(s_in[5]), .R6in(s_in[6]), .R7in(s_in[7]),
        .R8in(s_in[8]), .R9in(s_in[9]), .R10in(s_in[10]), .R11in(s_in[11]),
        .R12in(s_in[12]), .R13in(s_in[13]), .R14in(s_in[14]), .R15in(s_in[15]),
        .PCin(s_in[I_PC]), .HIin(s_in[I_HI]), .LOin(s_in[I_LO]), .Yin(s_in[I_Y]),
        .MARin(s_in[I_MAR]), .InPortIn(s_in[I_INP]), .Zin(s_in[I_Z]),
        .incPC(s_inc), .MDRin(s_in[I_MDR]), .read(s_read), .opcode(s_op),
        .R0out(s_out[0]), .R1out(s_out[1]), .R2out(s_out[2]), .R3out(s_out[3]),
        .R4out(s_out[4]), .R5out(s_out[5]), .R6out(s_out[6]), .R7out(s_out[7]),
        .R8out(s_out[8]), .R9out(s_out[9]), .R10out(s_out[10]), .R11out(s_out[11]),
        .R12out(s_out[12]), .R13out(s_out[13]), .R14out(s_out[14]), .R15out(s_out[15]),
        .PCout(s_out[O_PC]), .HIout(s_out[O_HI]), .LOout(s_out[O_LO]), .MDRout(s_out[O_MDR]),
        .InPortOut(s_out[O_INP]), .ZLowOut(s_out[O_ZL]), .ZHighOut(s_out[O_ZH]),
        .Mdatain(s_mdata)
`ifdef DATAPATH_DEBUG_EN
        , .bus_dbg(bus_dbg), .mar_dbg(mar_dbg), .pc_dbg(pc_dbg),
        .hi_dbg(hi_dbg), .lo_dbg(lo_dbg), .z_dbg(z_dbg)
`endif
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] model_bus();
        logic [31:0] b = '0;
        for (int i = 0; i < 16; i++) if (s_out[i]) b |= m_r[i];
        if (s_out[O_PC])  b |= m_pc;
        if (s_out[O_HI])  b |= m_hi;
        if (s_out[O_LO])  b |= m_lo;
        if (s_out[O_MDR]) b |= m_mdr;
        if (s_out[O_INP]) b |= m_inp;
        if (s_out[O_ZL])  b |= m_z[31:0];
        if (s_out[O_ZH])  b |= m_z[63:32];
        return b;
    endfunction

    function automatic logic [63:0] model_alu(input logic [31:0] a, input logic [31:0] b, input logic [4:0] op);
        int unsigned n = b[4:0];
        logic [31:0] x = a;
        longint la = longint'($signed(a));
        longint lb = longint'($signed(b));
        longint q, r, t;
        case (op)
            OP_ADD:  return {32'd0, a + b};
            OP_SUB:  return {32'd0, a - b};
            OP_AND:  return {32'd0, a & b};
            OP_OR:   return {32'd0, a | b};
            OP_SHR:  return {32'd0, a >> n};
            OP_SHRA: begin t = la >>> n; return {32'd0, t[31:0]}; end
            OP_SHL:  return {32'd0, a << n};
            OP_ROR:  begin for (int k = 0; k < n; k++) x = {x[0], x[31:1]}; return {32'd0, x}; end
            OP_ROL:  begin for (int k = 0; k < n; k++) x = {x[30:0], x[31]}; return {32'd0, x}; end
            OP_DIV:  begin
                if (b == 0) return 64'd0;
                q = la / lb;
                r = la % lb;
                return {r[31:0], q[31:0]};
            end
            OP_MUL:  begin t = la * lb; return t; end
            OP_NEG:  return {32'd0, -b};
            OP_NOT:  return {32'd0, ~b};
            default: return 64'd0;
        endcase
    endfunction

    // Compare all architectural state against the model.
    task automatic check_state();
        for (int i = 0; i < 16; i++) check($sformatf("R%0d", i), {32'd0, dut.r_regs[i]}, {32'd0, m_r[i]});
        check("PC",     {32'd0, dut.r_pc},     {32'd0, m_pc});
        check("HI",     {32'd0, dut.r_hi},     {32'd0, m_hi});
        check("LO",     {32'd0, dut.r_lo},     {32'd0, m_lo});
        check("Y",      {32'd0, dut.r_y},      {32'd0, m_y});
        check("MAR",    {32'd0, dut.r_mar},    {32'd0, m_mar});
        check("MDR",    {32'd0, dut.r_mdr},    {32'd0, m_mdr});
        check("InPort", {32'd0, dut.r_inport}, {32'd0, m_inp});
        check("Z",      dut.r_z,               m_z);
`ifdef DATAPATH_DEBUG_EN
        check("pc_dbg", {32'd0, pc_dbg}, {32'd0, m_pc});
        check("z_dbg",  z_dbg,           m_z);
`endif
    endtask

    // One control step: drive after negedge, check bus, clock it, update model, check state.
    task automatic step(input logic [23:0] in_m, input logic [22:0] out_m, input logic inc,
                        input logic rd, input logic [4:0] op, input logic [31:0] md, input logic clr_n);
        logic [31:0] b;
        logic [63:0] alu;
        s_in = in_m; s_out = out_m; s_inc = inc; s_read = rd; s_op = op; s_mdata = md; clear = clr_n;
        #1;
        b = model_bus();
        alu = model_alu(m_y, b, op);
        check("bus", {32'd0, dut.w_bus}, {32'd0, b});
        @(posedge clock);
        if (!clr_n) begin
            for (int i = 0; i < 16; i++) m_r[i] = '0;
            m_pc = '0; m_hi = '0; m_lo = '0; m_y = '0; m_mar = '0; m_mdr = '0; m_inp = '0; m_z = '0;
        end else begin
            for (int i = 0; i < 16; i++) if (in_m[i]) m_r[i] = b;
            if (in_m[I_PC]) m_pc = b; else if (inc) m_pc = m_pc + 1;
            if (in_m[I_HI])  m_hi  = b;
            if (in_m[I_LO])  m_lo  = b;
            if (in_m[I_Y])   m_y   = b;
            if (in_m[I_MAR]) m_mar = b;
            if (in_m[I_INP]) m_inp = b;
            if (in_m[I_Z])   m_z   = alu;
            if (in_m[I_MDR]) m_mdr = rd ? md : b;
        end
        #1;
        check_state();
        @(negedge clock);
    endtask

    task automatic simple(input logic [23:0] in_m, input logic [22:0] out_m);
        step(in_m, out_m, 1'b0, 1'b0, 5'd0, 32'd0, 1'b1);
    endtask

    task automatic load_mdr(input logic [31:0] v);
        step(24'(1) << I_MDR, '0, 1'b0, 1'b1, 5'd0, v, 1'b1);
    endtask

    // Y <= a, then Z <= ALU(Y, b).
    task automatic alu_case(input logic [31:0] a, input logic [31:0] b, input logic [4:0] op);
        load_mdr(a);
        simple(24'(1) << I_Y, 23'(1) << O_MDR);
        load_mdr(b);
        step(24'(1) << I_Z, 23'(1) << O_MDR, 1'b0, 1'b0, op, 32'd0, 1'b1);
    endtask

    initial begin
        logic [4:0] ops [13] = '{OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR, OP_SHRA, OP_SHL,
                                 OP_ROR, OP_ROL, OP_DIV, OP_MUL, OP_NEG, OP_NOT};
        for (int i = 0; i < 16; i++) m_r[i] = '0;
        m_pc = '0; m_hi = '0; m_lo = '0; m_y = '0; m_mar = '0; m_mdr = '0; m_inp = '0; m_z = '0;
        @(negedge clock);
        step('0, '0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0);

        // Reset overrides loads mid-sequence.
        load_mdr(32'd5);
        simple(24'(1) << 2, 23'(1) << O_MDR);
        check("R2_before_clear", {32'd0, dut.r_regs[2]}, 64'd5);
        step(24'hFFFFFF, 23'(1) << O_MDR, 1'b1, 1'b1, OP_ADD, 32'd9, 1'b0);
        check("R2_after_clear", {32'd0, dut.r_regs[2]}, 64'd0);
        check("MDR_after_clear", {32'd0, dut.r_mdr}, 64'd0);

        // MDR load path.
        load_mdr(32'd30);
        simple(24'(1) << 2, 23'(1) << O_MDR);
        load_mdr(32'd25);
        simple(24'(1) << 6, 23'(1) << O_MDR);
        check("R2_30", {32'd0, dut.r_regs[2]}, 64'd30);
        check("R6_25", {32'd0, dut.r_regs[6]}, 64'd25);

        // mul 30*25, then split into LO/HI.
        simple(24'(1) << I_Y, 23'(1) << 2);
        step(24'(1) << I_Z, 23'(1) << 6, 1'b0, 1'b0, OP_MUL, 32'd0, 1'b1);
        check("mul_z", dut.r_z, 64'd750);
        simple(24'(1) << I_LO, 23'(1) << O_ZL);
        simple(24'(1) << I_HI, 23'(1) << O_ZH);
        check("mul_lo", {32'd0, dut.r_lo}, 64'd750);
        check("mul_hi", {32'd0, dut.r_hi}, 64'd0);
        alu_case(-32'sd2, 32'd3, OP_MUL);
        check("mul_neg", dut.r_z, 64'hFFFF_FFFF_FFFF_FFFA);

        // div.
        alu_case(-32'sd7, 32'd2, OP_DIV);
        check("div_neg", dut.r_z, 64'hFFFF_FFFF_FFFF_FFFD);
        alu_case(32'd123, 32'd0, OP_DIV);
        check("div_zero", dut.r_z, 64'd0);

        // PC: increment, PCin priority, wrap.
        step(24'(1) << I_MAR, 23'(1) << O_PC, 1'b1, 1'b0, 5'd0, 32'd0, 1'b1);
        check("mar_pc0", {32'd0, dut.r_mar}, 64'd0);
        check("pc_inc", {32'd0, dut.r_pc}, 64'd1);
        load_mdr(32'h40);
        step(24'(1) << I_PC, 23'(1) << O_MDR, 1'b1, 1'b0, 5'd0, 32'd0, 1'b1);
        check("pc_prio", {32'd0, dut.r_pc}, 64'h40);
        load_mdr(32'hFFFF_FFFF);
        simple(24'(1) << I_PC, 23'(1) << O_MDR);
        step('0, '0, 1'b1, 1'b0, 5'd0, 32'd0, 1'b1);
        check("pc_wrap", {32'd0, dut.r_pc}, 64'd0);

        // Shifts and rotates.
        alu_case(32'h8000_0001, 32'd1, OP_SHRA);
        check("shra", dut.r_z, 64'hC000_0000);
        alu_case(32'h8000_0001, 32'd1, OP_SHR);
        check("shr", dut.r_z, 64'h4000_0000);
        alu_case(32'h8000_0001, 32'd1, OP_ROR);
        check("ror", dut.r_z, 64'hC000_0000);
        alu_case(32'h8000_0001, 32'd1, OP_ROL);
        check("rol", dut.r_z, 64'h0000_0003);
        alu_case(32'h1234_5678, 32'h1111_1111, 5'b11111);
        check("unused_op", dut.r_z, 64'd0);

        // Yin and Zin together: Z uses the old Y (Y=0x1234_5678 from the previous case).
        load_mdr(32'd1);
        step((24'(1) << I_Y) | (24'(1) << I_Z), 23'(1) << O_MDR, 1'b0, 1'b0, OP_ADD, 32'd0, 1'b1);
        check("y_z_same_step", dut.r_z, 64'h1234_5679);

        // Randomized control steps.
        for (int n = 0; n < 1500; n++) begin
            logic [23:0] im;
            logic [22:0] om;
            logic [4:0]  op;
            int          sel;
            im = '0;
            for (int k = 0; k < 24; k++) if ($urandom_range(0, 11) == 0) im[k] = 1'b1;
            sel = $urandom_range(0, 9);
            om = '0;
            if (sel >= 2) om[$urandom_range(0, 22)] = 1'b1;
            if (sel == 9) om[$urandom_range(0, 22)] = 1'b1;
            op = ($urandom_range(0, 7) == 0) ? 5'($urandom) : ops[$urandom_range(0, 12)];
            step(im, om, 1'($urandom), 1'($urandom), op,
                 ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom,
                 ($urandom_range(0, 59) == 0) ? 1'b0 : 1'b1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/datapath.md
Name: datapath

Overview:
- Single-bus 32-bit CPU datapath for the mini-CPU; the external control unit (or a bench) sequences it one control step per clock through one-hot register-out/register-in strobes.
- Holds a 16-entry general register file, PC, HI, LO, Y, 64-bit Z, MAR, MDR and an input-port register.
- Contains an ALU that combines Y with the bus under a 5-bit opcode and writes the 64-bit result to Z.

Parameters:
- WIDTH, 32, data/bus width. Z is 2*WIDTH.
- NREGS, 16, number of general registers R0..R15.

Ports:
- clock  in  1  rising-edge clock
- clear  in  1  synchronous, active-low reset
- R0in..R15in  in  1 each  load Rn from bus
- PCin, HIin, LOin, Yin, MARin, InPortIn  in  1 each  load that register from bus
- Zin  in  1  load Z with ALU result
- incPC  in  1  PC <= PC+1
- MDRin  in  1  load MDR
- read  in  1  MDR source select: 1 = Mdatain, 0 = bus
- opcode  in  5  ALU operation
- Mdatain  in  32  memory read data
- R0out..R15out, PCout, HIout, LOout, MDRout, InPortOut  in  1 each  drive that register onto the bus
- ZLowOut, ZHighOut  in  1 each  drive Z[31:0] or Z[63:32] onto the bus

Behaviour:
- Reset: at any rising clock edge with clear==0, all registers (R0..R15, PC, HI, LO, Y, Z, MAR, MDR, InPort) become 0. Reset overrides all load strobes, including in mid-sequence.
- Bus (combinational): bitwise OR of every source whose out strobe is 1; bus is 0 when none are asserted. The controller guarantees at most one out strobe per step; multiple asserted strobes yield the OR, with no error flagged.
- Register loads: on a rising edge, each register whose in strobe is 1 captures the bus. Several in strobes in the same step all capture the same value.
- PC: PCin has priority over incPC. With incPC only, PC <= PC+1, wrapping from 0xFFFFFFFF to 0.
- MDR: on MDRin, MDR <= (read ? Mdatain : bus).
- Z: on Zin, Z <= ALU(A=Y, B=bus, opcode). The ALU is purely combinational, so a result is available one edge after Zin.
- Zin with Yin in the same step: Z uses the old Y value.
- ALU opcodes (32-bit results are zero-extended into Z[63:32] unless noted):
  - 00011 add: A+B, carry-out discarded
  - 00100 sub: A-B
  - 00101 and
  - 00110 or
  - 00111 shr: logical shift right by B[4:0]
  - 01000 shra: arithmetic shift right by B[4:0]
  - 01001 shl: shift left by B[4:0]
  - 01010 ror: rotate right by B[4:0]
  - 01011 rol: rotate left by B[4:0]
  - 01111 div: signed; Z[31:0] = quotient, Z[63:32] = remainder (remainder takes the dividend's sign). B==0 gives Z=0.
  - 10000 mul: signed 32x32 product as full 64 bits
  - 10001 neg: two's complement of B
  - 10010 not: ~B
  - any other opcode: Z result = 0
- Latency: every transfer completes in one clock. MAR has no external output in the base build.

Optional Feature:
- Macro DATAPATH_DEBUG_EN.
- Defined: adds outputs bus_dbg[31:0] (live bus), mar_dbg[31:0], pc_dbg[31:0], hi_dbg[31:0], lo_dbg[31:0] and z_dbg[63:0] for bench observation.
- Undefined: these ports do not exist; core behaviour is identical either way.

Decomposition:
- Shared package datapath_pkg holds the opcode localparams (OP_ADD ... OP_NOT) and WIDTH.
- One sub-module, datapath_alu: combinational; inputs a, b, opcode; output 64-bit result.
- Registers and the bus mux stay in datapath.

Test Plan:
- Reset: load R2=5, then assert clear=0 for one edge -> all registers read 0 (via MDRout/debug ports).
- MDR load path: Mdatain=30 with read=1, MDRin=1; next step MDRout=1, R2in=1 -> R2=30. Repeat with Mdatain=25 into R6 -> R6=25.
- mul: R2=30, R6=25. R2out+Yin, then R6out+Zin with opcode=10000 -> Z=750. ZLowOut+LOin -> LO=750; ZHighOut+HIin -> HI=0. Second case: Y=-2, B=3 -> Z=64'hFFFF_FFFF_FFFF_FFFA.
- div: Y=-7, B=2, opcode 01111 -> Z[31:0]=-3, Z[63:32]=-1. B=0 -> Z=0.
- PC: PCout+MARin+incPC with PC=0 -> MAR=0, PC=1. PCin and incPC together with bus=0x40 -> PC=0x40. PC=0xFFFFFFFF with incPC -> PC=0.
- Shifts/rotate: Y=0x80000001, B=1. shra -> 0xC0000000; shr -> 0x40000000; ror -> 0xC0000000; rol -> 0x00000003. Unused opcode 11111 -> Z=0.
